// File: rtl/icache_ctrl.sv
// icache_ctrl: read-only, direct-mapped instruction cache.
// 8 lines of 4 words each, with a 3-bit tag per line.
// A hit returns its word combinationally in the same cycle.
// A miss fetches the whole 16-byte block from instruction memory.
// The fetch passes through MEM_FETCH and UPDATE and then returns to IDLE.
module icache_ctrl (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [9:0]   ADDRESS,
  input  logic         READ,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic [5:0]   MEM_ADDRESS,
  output logic         MEM_READ,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE,
    MEM_FETCH,
    UPDATE
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   miss_addr_q, miss_addr_d;
  logic         first_q, first_d;
  logic [7:0]   valid_q, valid_d;
  logic [2:0]   tag_q  [8];
  logic [2:0]   tag_d  [8];
  logic [127:0] data_q [8];
  logic [127:0] data_d [8];

  logic [2:0]   addr_tag;
  logic [2:0]   addr_idx;
  logic [1:0]   addr_word;
  logic [127:0] sel_line;
  logic         hit;
  logic         fill;

  // Split the byte address into its fields; bits [1:0] are deliberately unused.
  always_comb begin
    addr_tag  = ADDRESS[9:7];
    addr_idx  = ADDRESS[6:4];
    addr_word = ADDRESS[3:2];
  end

  // Detect a hit, and select the addressed word from the indexed line.
  always_comb begin
    sel_line = data_q[addr_idx];
    hit      = READ && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    case (addr_word)
      2'd0:    READDATA = sel_line[31:0];
      2'd1:    READDATA = sel_line[63:32];
      2'd2:    READDATA = sel_line[95:64];
      default: READDATA = sel_line[127:96];
    endcase
  end

  // Miss FSM: next state and memory handshake outputs.
  // The first_q flag ensures MEM_READ stays up for at least one full cycle
  // before a low MEM_BUSYWAIT is trusted.
  // BUSYWAIT is forced low while RESET is held, so the CPU never stalls during reset.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    first_d     = 1'b0;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = 6'd0;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (READ && !hit) begin
          BUSYWAIT    = 1'b1;
          miss_addr_d = {addr_tag, addr_idx};
          first_d     = 1'b1;
          state_d     = MEM_FETCH;
        end
      end
      MEM_FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = miss_addr_q;
        if (!first_q && !MEM_BUSYWAIT) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        fill     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!RESET) begin
      BUSYWAIT = 1'b0;
    end
  end

  // Line fill: the captured miss address picks the line, never the live ADDRESS.
  // This keeps the write unaffected when the CPU changes its address mid-fetch.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill) begin
      valid_d[miss_addr_q[2:0]] = 1'b1;
      tag_d[miss_addr_q[2:0]]   = miss_addr_q[5:3];
      data_d[miss_addr_q[2:0]]  = MEM_READDATA;
    end
  end

  // Control state and valid bits clear asynchronously.
  // A reset in mid-fill therefore leaves the target line invalid.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      miss_addr_q <= 6'd0;
      first_q     <= 1'b0;
      valid_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      first_q     <= first_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data storage has no reset; it is only trusted once its valid bit is set.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboard bench for icache_ctrl.
// A behavioural instruction memory returns each block 5 cycles after MEM_READ rises.
// Word w of block b reads back as b*4+w.
module tb_icache_ctrl;

  logic         CLK;
  logic         RESET;
  logic [9:0]   ADDRESS;
  logic         READ;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic [5:0]   MEM_ADDRESS;
  logic         MEM_READ;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  typedef struct {
    logic [31:0] word;
    int          busy;
  } exp_t;

  exp_t       sbQ[$];
  logic [5:0] fetchQ[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] tbValid;
  logic [2:0] tbTag [8];

  logic [2:0]   memCnt;
  logic [127:0] memData;

  icache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .READ         (READ),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READ     (MEM_READ),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  // Free-running clock with a 10-unit period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] memWord(input logic [5:0] blk, input logic [1:0] w);
    return {24'd0, blk, w};
  endfunction

  function automatic logic [127:0] memBlock(input logic [5:0] blk);
    return {memWord(blk, 2'd3), memWord(blk, 2'd2), memWord(blk, 2'd1), memWord(blk, 2'd0)};
  endfunction

  // Memory model: busy for the first 4 cycles of a request.
  // The block is latched while the request is up and held until the cache fills from it.
  always @(posedge CLK) begin
    if (MEM_READ) begin
      memCnt  <= memCnt + 3'd1;
      memData <= memBlock(MEM_ADDRESS);
    end else begin
      memCnt  <= 3'd0;
    end
  end

  assign MEM_BUSYWAIT = MEM_READ && (memCnt < 3'd4);
  assign MEM_READDATA = memData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Update the reference directory for one request and return the stall it costs.
  function automatic int modelAccess(input logic [9:0] addr);
    logic [2:0] idx;
    idx = addr[6:4];
    if (tbValid[idx] && tbTag[idx] == addr[9:7]) begin
      return 0;
    end
    fetchQ.push_back(addr[9:4]);
    tbValid[idx] = 1'b1;
    tbTag[idx]   = addr[9:7];
    return 7;
  endfunction

  // Drive one fetch and optionally switch ADDRESS to addr2 after switchAt stall cycles.
  // Then follow the stall, checking MEM_ADDRESS each cycle.
  // Finally pop the scoreboard and check the stall length and READDATA.
  task automatic applyStimulus(input logic [9:0] addr, input logic [9:0] addr2, input int switchAt);
    exp_t       e;
    exp_t       got;
    int         c;
    logic       prevRead;
    logic [5:0] cur;
    logic [9:0] fin;
    e.busy = modelAccess(addr);
    fin    = addr;
    if (switchAt > 0) begin
      e.busy += modelAccess(addr2);
      fin = addr2;
    end
    e.word = memWord(fin[9:4], fin[3:2]);
    sbQ.push_back(e);
    @(posedge CLK);
    #1;
    ADDRESS  = addr;
    READ     = 1'b1;
    c        = 0;
    prevRead = 1'b0;
    cur      = 6'd0;
    forever begin
      @(negedge CLK);
      if (MEM_READ && !prevRead) begin
        if (fetchQ.size() == 0) begin
          checkOutput("unexpected_mem_read", 32'(MEM_READ), 32'd0);
        end else begin
          cur = fetchQ.pop_front();
        end
      end
      if (MEM_READ) begin
        checkOutput("mem_address", 32'(MEM_ADDRESS), 32'(cur));
      end else begin
        checkOutput("mem_address_idle", 32'(MEM_ADDRESS), 32'd0);
      end
      prevRead = MEM_READ;
      if (!BUSYWAIT) break;
      c++;
      if (c >= 60) begin
        checkOutput("busy_bound", 32'(BUSYWAIT), 32'd0);
        break;
      end
      @(posedge CLK);
      #1;
      if (switchAt > 0 && c == switchAt) begin
        ADDRESS = addr2;
      end
    end
    got = sbQ.pop_front();
    checkOutput("busy_cycles", c, got.busy);
    checkOutput("readdata", READDATA, got.word);
  endtask

  initial begin
    tbValid = 8'd0;
    for (int i = 0; i < 8; i++) tbTag[i] = 3'd0;
    RESET   = 1'b0;
    READ    = 1'b1;
    ADDRESS = 10'h000;

    // Reset state, with a pending request that must not stall.
    repeat (2) @(negedge CLK);
    checkOutput("rst_busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("rst_mem_read", 32'(MEM_READ), 32'd0);
    checkOutput("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("idle_busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("idle_mem_read", 32'(MEM_READ), 32'd0);

    // Cold miss on line 0, then word hits, with the byte offset ignored.
    applyStimulus(10'h000, 10'h000, 0);
    applyStimulus(10'h004, 10'h000, 0);
    applyStimulus(10'h008, 10'h000, 0);
    applyStimulus(10'h00C, 10'h000, 0);
    applyStimulus(10'h005, 10'h000, 0);
    applyStimulus(10'h006, 10'h000, 0);
    applyStimulus(10'h007, 10'h000, 0);

    // Conflict on index 0: replacement, then the old tag misses again.
    applyStimulus(10'h080, 10'h000, 0);
    applyStimulus(10'h08C, 10'h000, 0);
    applyStimulus(10'h000, 10'h000, 0);

    // Address changes mid-fetch: line 1 still fills, and then line 2 misses.
    applyStimulus(10'h010, 10'h020, 2);
    applyStimulus(10'h014, 10'h000, 0);

    // Reset in mid-fetch aborts the fill.
    @(posedge CLK);
    #1;
    ADDRESS = 10'h030;
    READ    = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("fetch_active", 32'(MEM_READ), 32'd1);
    checkOutput("fetch_address", 32'(MEM_ADDRESS), 32'h03);
    RESET = 1'b0;
    READ  = 1'b0;
    #1;
    checkOutput("abort_mem_read", 32'(MEM_READ), 32'd0);
    checkOutput("abort_busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("abort_mem_address", 32'(MEM_ADDRESS), 32'd0);
    tbValid = 8'd0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    applyStimulus(10'h030, 10'h000, 0);
    applyStimulus(10'h000, 10'h000, 0);
    applyStimulus(10'h024, 10'h000, 0);

    checkOutput("fetch_queue_empty", 32'(fetchQ.size()), 32'd0);
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
